// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// A bus write loads a shadow register. The shadow is copied into the display
// register only at frame boundaries, so a digit never shows a half-updated value.
// Each digit slot starts with a ghost interval during which every anode is off.
//
// Handshake: the write port has no backpressure. When `we` is high at a rising
// edge, that edge captures wdata[23:0]. There is no ready signal. rdata shows
// the captured value from the following cycle.
module sseg_scan_driver #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int GHOST_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

  logic [23:0]   shadow_q;
  logic [23:0]   disp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          run_q;
  logic          frame_end;
  logic          ghost;
  logic [3:0]    nib;
  logic [3:0]    blank_mask;
  logic [3:0]    dp_mask;
  logic          digit_on;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          unused_wdata;

  // Upper write byte carries no state.
  assign unused_wdata = ^wdata[31:24];

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Ghost phase is the first GHOST_CYCLES counts of every slot. It does not exist when GHOST_CYCLES is 0.
  generate
    if (GHOST_CYCLES == 0) begin : g_no_ghost
      assign ghost = 1'b0;
    end else begin : g_ghost
      localparam logic [CW-1:0] GHOST_END = CW'(GHOST_CYCLES);
      assign ghost = (cnt_q < GHOST_END);
    end
  endgenerate

  assign frame_end = run_q && (cnt_q == CNT_LAST) && (idx_q == 2'd3);

  // Slot counter wraps at REFRESH_CYCLES-1. On each wrap the digit index steps to the next digit.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Compute the next value of the outputs from the current counter, index and display register.
  always_comb begin
    blank_mask = disp_q[19:16];
    dp_mask    = disp_q[23:20];
    nib        = disp_q[{idx_q, 2'b00} +: 4];
    digit_on   = run_q && !ghost && !blank_mask[idx_q];
    an_d       = 4'hF;
    seg_d      = 7'h7F;
    dp_d       = 1'b1;
    if (digit_on) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(nib);
      dp_d  = ~dp_mask[idx_q];
    end
  end

  // Bus-visible shadow register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (we) begin
      shadow_q <= wdata[23:0];
    end
  end

  // Scan state. The counter holds at 0 for the first cycle after reset release,
  // which gives the display one extra settling cycle before the scan starts.
  // At a frame boundary the display register loads the shadow. If a write lands
  // on the same edge, the display gets the shadow value from before that write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      disp_q <= '0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (frame_end) begin
        disp_q <= shadow_q;
      end
    end
  end

  // Registered pad drivers, all off during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign rdata = {8'h00, shadow_q};

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Testbench for sseg_scan_driver: reference model plus vector table plus corner sequences.
module tb_sseg_scan_driver;

  localparam int R = 8;
  localparam int G = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  sseg_scan_driver #(.REFRESH_CYCLES(R), .GHOST_CYCLES(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // The reference model tracks the position inside the frame (0..4R-1) plus the two registers.
  bit          m_run = 1'b0;
  int          m_p = 0;
  logic [23:0] m_shadow = '0;
  logic [23:0] m_disp = '0;
  logic [3:0]  prev_an = 4'hF;

  // These record what each digit showed during a window of cycles.
  logic [6:0] obs_seg [4];
  logic       obs_dp  [4];
  bit         obs_lit [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) begin
      obs_seg[i] = 7'h7F;
      obs_dp[i]  = 1'b1;
      obs_lit[i] = 1'b0;
    end
  endtask

  // Advance one clock and compare against the model. The caller sets the inputs beforehand.
  task automatic step();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          cnt;
    int          idx;
    cnt   = m_p % R;
    idx   = (m_p / R) % 4;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (rst_n && m_run && cnt >= G && !m_disp[16 + idx]) begin
      e_an  = ~(4'b0001 << idx);
      e_seg = hex_tbl[m_disp[4*idx +: 4]];
      e_dp  = ~m_disp[20 + idx];
    end
    if (!rst_n) begin
      m_run = 1'b0; m_p = 0; m_shadow = '0; m_disp = '0;
    end else begin
      if (m_run && cnt == R-1 && idx == 3) m_disp = m_shadow;
      if (we) m_shadow = wdata[23:0];
      if (m_run) m_p = (m_p + 1) % (4*R);
      m_run = 1'b1;
    end
    @(posedge clk);
    #1;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("rdata", rdata, {8'h00, m_shadow});
    check("an_onehot", ($countones(~an) <= 1), 1);
    check("dark_off", ((an != 4'hF) || (seg == 7'h7F && dp == 1'b1)), 1);
    check("handover", ((prev_an == 4'hF) || (an == 4'hF) || (an == prev_an)), 1);
    prev_an = an;
    for (int i = 0; i < 4; i++) begin
      if (an[i] == 1'b0) begin
        obs_lit[i] = 1'b1;
        obs_seg[i] = seg;
        obs_dp[i]  = dp;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // After reset release, digit 0 should first light on the fourth edge (E0+3).
  task automatic expect_first_digit(input string name);
    int  k;
    bit  seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      step();
      k++;
      if (an == 4'hE) begin
        seen = 1'b1;
        check(name, k, G + 2);
        check({name, "_seg"}, seg, 7'h40);
      end
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [31:0] wdata;
    logic [27:0] segs;   // {d3,d2,d1,d0}
    logic [3:0]  dps;    // expected dp pin level per digit
    logic [3:0]  lit;    // digits that must light
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{32'h0000_1234, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b1111};
    vecs[1] = '{32'h005A_BEEF, {7'h7F, 7'h06, 7'h7F, 7'h0E}, 4'b1010, 4'b0101};
    vecs[2] = '{32'h00F0_89AC, {7'h00, 7'h10, 7'h08, 7'h46}, 4'b0000, 4'b1111};
    vecs[3] = '{32'hFF0F_5670, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, 4'b0000};
    vecs[4] = '{32'h0030_67D0, {7'h02, 7'h78, 7'h21, 7'h40}, 4'b1100, 4'b1111};

    clear_obs();

    // Reset held low with a write pending.
    rst_n = 1'b0; we = 1'b1; wdata = 32'h00FF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_rdata", rdata, 32'h0);
    end
    we = 1'b0; wdata = '0; rst_n = 1'b1;
    expect_first_digit("first_digit_after_reset");

    // Table: write, wait out a full frame, then observe a complete frame.
    for (int v = 0; v < 5; v++) begin
      we = 1'b1; wdata = vecs[v].wdata;
      step();
      we = 1'b0;
      check("vec_rdata", rdata, {8'h00, vecs[v].wdata[23:0]});
      run_cycles(4*R + 2);
      clear_obs();
      run_cycles(4*R);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("vec%0d_lit%0d", v, i), obs_lit[i], vecs[v].lit[i]);
        if (vecs[v].lit[i]) begin
          check($sformatf("vec%0d_seg%0d", v, i), obs_seg[i], vecs[v].segs[7*i +: 7]);
          check($sformatf("vec%0d_dp%0d", v, i), obs_dp[i], vecs[v].dps[i]);
        end
      end
    end

    // Write on the same edge as the frame boundary.
    we = 1'b1; wdata = 32'h0000_1111;
    step();
    we = 1'b0;
    run_cycles(4*R + 2);
    begin
      int guard;
      guard = 0;
      while (!(m_run && m_p == 4*R - 1) && guard < 100) begin
        step();
        guard++;
      end
      check("collision_reach", (guard < 100), 1);
    end
    we = 1'b1; wdata = 32'h0000_2222;
    step();
    we = 1'b0;
    check("collision_rdata", rdata, 32'h0000_2222);
    clear_obs();
    run_cycles(4*R);
    check("collision_old_d0", obs_seg[0], 7'h79);
    check("collision_old_d3", obs_seg[3], 7'h79);
    clear_obs();
    run_cycles(4*R);
    check("collision_new_d0", obs_seg[0], 7'h24);
    check("collision_new_d3", obs_seg[3], 7'h24);

    // Reset while digit 2 is lit.
    begin
      int guard;
      guard = 0;
      while (an != 4'hB && guard < 100) begin
        step();
        guard++;
      end
      check("midscan_reach", (guard < 100), 1);
    end
    rst_n = 1'b0;
    step();
    check("midscan_rst_an", an, 4'hF);
    check("midscan_rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    expect_first_digit("first_digit_after_midscan");
    run_cycles(4*R);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      we    = ($urandom_range(0, 9) == 0);
      wdata = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1; we = 1'b0;
    run_cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
